// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and
// the default halt / no-op instruction values.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } fetch_state_e;

    // Wide enough for any practical instruction width; sliced by the user.
    localparam logic [63:0] DEFAULT_HALT_WORD = '1;
    localparam logic [63:0] NOP_WORD          = '0;

endpackage

// File: rtl/instr_mem.sv
// Instruction storage: synchronous write port, combinational read port.
module instr_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register, run/step/halt
// control and the loader path into instruction memory.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PC_LENGTH          = 32,
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int MEM_DEPTH          = 256,
    parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD =
        DEFAULT_HALT_WORD[INSTRUCTION_LENGTH-1:0]
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mips_enable,
    input  logic                          step_mode,
    input  logic                          step,
    input  logic                          stall,
    input  logic                          jump,
    input  logic [PC_LENGTH-1:0]          pc_with_jump,
    input  logic                          wr_memory_instruction_enable,
    input  logic [PC_LENGTH-1:0]          address_to_write,
    input  logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
    output logic [PC_LENGTH-1:0]          program_counter,
    output logic [INSTRUCTION_LENGTH-1:0] if_instruction,
    output logic [PC_LENGTH-1:0]          if_pc_next,
    output logic                          if_valid,
    output logic                          halted,
    output logic [1:0]                    state
);

    localparam int ADDR_BITS = $clog2(MEM_DEPTH);
    localparam logic [PC_LENGTH-1:0]          PC_STEP = PC_LENGTH'(4);
    localparam logic [INSTRUCTION_LENGTH-1:0] NOP     = NOP_WORD[INSTRUCTION_LENGTH-1:0];

    fetch_state_e                  state_q, state_d;
    logic [PC_LENGTH-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_LENGTH-1:0] instr_q, instr_d;
    logic [PC_LENGTH-1:0]          pc_next_q, pc_next_d;
    logic                          valid_q, valid_d;

    logic [INSTRUCTION_LENGTH-1:0] mem_rd_data;
    logic [INSTRUCTION_LENGTH-1:0] fetch_word;
    logic                          fetch_in_range;
    logic                          wr_in_range;
    logic                          mem_wr_en;
    logic                          unused_addr_lsbs;

    // An address is inside the memory when every bit above the word index is zero.
    assign fetch_in_range = (pc_q[PC_LENGTH-1:ADDR_BITS+2] == '0);
    assign wr_in_range    = (address_to_write[PC_LENGTH-1:ADDR_BITS+2] == '0);
    assign fetch_word     = fetch_in_range ? mem_rd_data : NOP;

    // The loader may only touch memory while nothing is being fetched.
    assign mem_wr_en = !reset && wr_memory_instruction_enable && wr_in_range &&
                       ((state_q == ST_IDLE) || (state_q == ST_HALTED));

    assign unused_addr_lsbs = ^address_to_write[1:0];

    instr_mem #(
        .WIDTH (INSTRUCTION_LENGTH),
        .DEPTH (MEM_DEPTH)
    ) u_instr_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (address_to_write[ADDR_BITS+1:2]),
        .wr_data (instruction_to_write),
        .rd_addr (pc_q[ADDR_BITS+1:2]),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mips_enable) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN, ST_STEP: begin
                if (jump) begin
                    pc_d    = pc_with_jump;
                    instr_d = NOP;
                end else if (stall) begin
                    valid_d = valid_q;
                end else if ((state_q == ST_RUN) || step) begin
                    instr_d   = fetch_word;
                    pc_next_d = pc_q + PC_STEP;
                    pc_d      = pc_q + PC_STEP;
                    valid_d   = 1'b1;
                    if (fetch_word == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign program_counter = pc_q;
    assign if_instruction  = instr_q;
    assign if_pc_next      = pc_next_q;
    assign if_valid        = valid_q;
    assign halted          = (state_q == ST_HALTED);
    assign state           = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected fetches are queued as they
// are launched and compared when the IF/ID register updates.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        mips_enable;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        jump;
    logic [31:0] pc_with_jump;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] program_counter;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_next;
    logic        if_valid;
    logic        halted;
    logic [1:0]  state;

    fetch_stage #(
        .PC_LENGTH          (32),
        .INSTRUCTION_LENGTH (32),
        .MEM_DEPTH          (256)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .mips_enable                  (mips_enable),
        .step_mode                    (step_mode),
        .step                         (step),
        .stall                        (stall),
        .jump                         (jump),
        .pc_with_jump                 (pc_with_jump),
        .wr_memory_instruction_enable (wr_en),
        .address_to_write             (wr_addr),
        .instruction_to_write         (wr_data),
        .program_counter              (program_counter),
        .if_instruction               (if_instruction),
        .if_pc_next                   (if_pc_next),
        .if_valid                     (if_valid),
        .halted                       (halted),
        .state                        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tb_mem [256];
    logic [31:0] model_pc;
    int          pass_cnt;
    int          total_cnt;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return (a >= 32'd1024) ? 32'h0 : tb_mem[a[9:2]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (accept) tb_mem[a[9:2]] = d;
        $display("load addr=%h data=%h accepted=%0d", a, d, accept);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs [6];
        logic [31:0] expv[6];
        reset       = 1'b1;
        mips_enable = 1'b1;
        tick();
        tick();
        obs = '{32'(state), program_counter, if_instruction, if_pc_next,
                32'(if_valid), 32'(halted)};
        expv = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (obs[i] !== expv[i])
                $display("FAIL reset_field%0d: got %h expected %h", i, obs[i], expv[i]);
            else
                pass_cnt++;
        end
        reset       = 1'b0;
        mips_enable = 1'b0;
        $display("reset checked");
    endtask

    // Loads the program, runs 0x11,0x22,0x33 then the halt word at 12.
    task automatic test_run_to_halt();
        exp_t e;
        load(32'h000, 32'h11, 1);
        load(32'h004, 32'h22, 1);
        load(32'h008, 32'h33, 1);
        load(32'h00C, HALT, 1);
        load(32'h01C, 32'h77, 1);
        load(32'h040, 32'h66, 1);
        load(32'h400, 32'hBAD, 0);
        mips_enable = 1'b1;
        step_mode   = 1'b0;
        tick();
        mips_enable = 1'b0;
        total_cnt++;
        if (state !== 2'b01 || if_valid !== 1'b0 || program_counter !== 32'd0)
            $display("FAIL run_entry: got state=%b v=%b pc=%h expected state=01 v=0 pc=0",
                     state, if_valid, program_counter);
        else pass_cnt++;
        model_pc = 32'd0;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            tick();
            e = sb_q.pop_front();
            $display("fetch instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next)
                $display("FAIL run_fetch%0d: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                         i, if_valid, if_instruction, if_pc_next, e.instr, e.pc_next);
            else pass_cnt++;
        end
        total_cnt++;
        if (halted !== 1'b1 || state !== 2'b11 || program_counter !== 32'd16)
            $display("FAIL halt_entry: got halted=%b state=%b pc=%h expected 1 11 00000010",
                     halted, state, program_counter);
        else pass_cnt++;
        mips_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (if_valid !== 1'b0 || halted !== 1'b1 || program_counter !== 32'd16)
                $display("FAIL halt_hold%0d: got v=%b halted=%b pc=%h expected v=0 halted=1 pc=00000010",
                         i, if_valid, halted, program_counter);
            else pass_cnt++;
        end
        mips_enable = 1'b0;
        load(32'h000, 32'h55, 1);
    endtask

    task automatic test_stall_jump();
        exp_t        e;
        logic [31:0] targets [3];
        pulse_reset();
        mips_enable = 1'b1;
        tick();
        mips_enable = 1'b0;
        model_pc = 32'd0;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            tick();
            e = sb_q.pop_front();
            $display("fetch instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next)
                $display("FAIL pre_stall%0d: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                         i, if_valid, if_instruction, if_pc_next, e.instr, e.pc_next);
            else pass_cnt++;
        end
        // A loader write during RUN must be dropped.
        stall   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 32'h004;
        wr_data = 32'h99;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (program_counter !== 32'd8 || if_instruction !== 32'h22 ||
                if_pc_next !== 32'd8 || if_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got pc=%h instr=%h pcn=%h v=%b expected pc=8 instr=22 pcn=8 v=1",
                         i, program_counter, if_instruction, if_pc_next, if_valid);
            else pass_cnt++;
        end
        wr_en = 1'b0;
        targets = '{32'h40, 32'h400, 32'hFFFF_FFFC};
        for (int t = 0; t < 3; t++) begin
            jump         = 1'b1;
            pc_with_jump = targets[t];
            tick();
            jump  = 1'b0;
            stall = 1'b0;
            total_cnt++;
            if (program_counter !== targets[t] || if_valid !== 1'b0 || if_instruction !== 32'h0)
                $display("FAIL jump%0d: got pc=%h v=%b instr=%h expected pc=%h v=0 instr=0",
                         t, program_counter, if_valid, if_instruction, targets[t]);
            else pass_cnt++;
            model_pc = targets[t];
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            tick();
            e = sb_q.pop_front();
            $display("fetch instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next ||
                program_counter !== model_pc)
                $display("FAIL jump_fetch%0d: got v=%b instr=%h pcn=%h pc=%h expected v=1 instr=%h pcn=%h pc=%h",
                         t, if_valid, if_instruction, if_pc_next, program_counter,
                         e.instr, e.pc_next, model_pc);
            else pass_cnt++;
        end
        // After the wrap the PC is 0 again: words 0 and 4 must be unaltered.
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            tick();
            e = sb_q.pop_front();
            $display("fetch instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next)
                $display("FAIL wrap_fetch%0d: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                         i, if_valid, if_instruction, if_pc_next, e.instr, e.pc_next);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_run();
        exp_t e;
        pulse_reset();
        mips_enable = 1'b1;
        tick();
        jump         = 1'b1;
        pc_with_jump = 32'h1C;
        tick();
        jump = 1'b0;
        tick();
        total_cnt++;
        if (program_counter !== 32'h20 || if_instruction !== 32'h77)
            $display("FAIL pre_reset: got pc=%h instr=%h expected pc=00000020 instr=00000077",
                     program_counter, if_instruction);
        else pass_cnt++;
        reset   = 1'b1;
        step    = 1'b1;
        jump    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 32'h0;
        wr_data = 32'hDEAD;
        tick();
        step  = 1'b0;
        jump  = 1'b0;
        wr_en = 1'b0;
        total_cnt++;
        if (state !== 2'b00 || program_counter !== 32'd0 || if_instruction !== 32'd0 ||
            if_pc_next !== 32'd0 || if_valid !== 1'b0 || halted !== 1'b0)
            $display("FAIL reset_in_run: got state=%b pc=%h instr=%h pcn=%h v=%b halted=%b expected all zero",
                     state, program_counter, if_instruction, if_pc_next, if_valid, halted);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        mips_enable = 1'b0;
        model_pc = 32'd0;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            tick();
            e = sb_q.pop_front();
            $display("fetch instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next)
                $display("FAIL restart_fetch%0d: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                         i, if_valid, if_instruction, if_pc_next, e.instr, e.pc_next);
            else pass_cnt++;
        end
    endtask

    task automatic test_step();
        exp_t e;
        int   valid_cycles;
        pulse_reset();
        step_mode   = 1'b1;
        mips_enable = 1'b1;
        tick();
        mips_enable = 1'b0;
        step_mode   = 1'b0;
        total_cnt++;
        if (state !== 2'b10)
            $display("FAIL step_entry: got state=%b expected 10", state);
        else pass_cnt++;
        step  = 1'b1;
        stall = 1'b1;
        tick();
        step  = 1'b0;
        stall = 1'b0;
        total_cnt++;
        if (program_counter !== 32'd0 || if_valid !== 1'b0)
            $display("FAIL step_stalled: got pc=%h v=%b expected pc=0 v=0", program_counter, if_valid);
        else pass_cnt++;
        valid_cycles = 0;
        model_pc     = 32'd0;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{model_word(model_pc), model_pc + 32'd4});
            model_pc = model_pc + 32'd4;
            step = 1'b1;
            tick();
            step = 1'b0;
            if (if_valid === 1'b1) valid_cycles++;
            e = sb_q.pop_front();
            $display("step instr=%h pc_next=%h v=%b", if_instruction, if_pc_next, if_valid);
            total_cnt++;
            if (if_valid !== 1'b1 || if_instruction !== e.instr || if_pc_next !== e.pc_next)
                $display("FAIL step_fetch%0d: got v=%b instr=%h pcn=%h expected v=1 instr=%h pcn=%h",
                         i, if_valid, if_instruction, if_pc_next, e.instr, e.pc_next);
            else pass_cnt++;
            for (int k = 0; k < 2; k++) begin
                tick();
                if (if_valid === 1'b1) valid_cycles++;
            end
        end
        total_cnt++;
        if (valid_cycles != 3 || program_counter !== 32'd12 || state !== 2'b10)
            $display("FAIL step_summary: got valid_cycles=%0d pc=%h state=%b expected 3 0000000c 10",
                     valid_cycles, program_counter, state);
        else pass_cnt++;
        step         = 1'b1;
        jump         = 1'b1;
        pc_with_jump = 32'h4;
        tick();
        step = 1'b0;
        jump = 1'b0;
        total_cnt++;
        if (program_counter !== 32'h4 || if_valid !== 1'b0 || if_instruction !== 32'h0)
            $display("FAIL step_jump: got pc=%h v=%b instr=%h expected pc=4 v=0 instr=0",
                     program_counter, if_valid, if_instruction);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        reset        = 1'b1;
        mips_enable  = 1'b0;
        step_mode    = 1'b0;
        step         = 1'b0;
        stall        = 1'b0;
        jump         = 1'b0;
        pc_with_jump = 32'h0;
        wr_en        = 1'b0;
        wr_addr      = 32'h0;
        wr_data      = 32'h0;
        test_reset();
        test_run_to_halt();
        test_stall_jump();
        test_reset_in_run();
        test_step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_LENGTH, default 32: program counter width in bits.
REQ-002 Parameter INSTRUCTION_LENGTH, default 32: instruction word width in bits.
REQ-003 Parameter MEM_DEPTH, default 256: instruction memory depth in words, a power of two.
REQ-004 Parameter HALT_WORD, default all ones: instruction encoding that stops fetching.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port mips_enable, input, 1: start request; level-sensitive.
REQ-008 Port step_mode, input, 1: 1 selects single-step execution, sampled in IDLE only.
REQ-009 Port step, input, 1: one-cycle pulse advancing one fetch in step mode.
REQ-010 Port stall, input, 1: hazard hold from the decode stage.
REQ-011 Port jump, input, 1: redirect request.
REQ-012 Port pc_with_jump, input, PC_LENGTH: redirect target, byte address.
REQ-013 Port wr_memory_instruction_enable, input, 1: loader write strobe.
REQ-014 Port address_to_write, input, PC_LENGTH: loader byte address.
REQ-015 Port instruction_to_write, input, INSTRUCTION_LENGTH: loader data.
REQ-016 Port program_counter, output, PC_LENGTH: current fetch address.
REQ-017 Port if_instruction, output, INSTRUCTION_LENGTH: IF/ID instruction register.
REQ-018 Port if_pc_next, output, PC_LENGTH: IF/ID copy of fetched address + 4.
REQ-019 Port if_valid, output, 1: IF/ID register holds a real instruction.
REQ-020 Port halted, output, 1: HALT_WORD fetched; sticky.
REQ-021 Port state, output, 2: FSM state encoding.

Function
REQ-022 The FSM SHALL have these states: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-023 In IDLE, mips_enable=1 SHALL move the FSM to STEP if step_mode=1, otherwise to RUN.
REQ-024 A fetch SHALL occur each cycle in RUN, and in STEP only in a cycle with step=1; stall=1 suppresses a fetch.
REQ-025 A fetch SHALL load if_instruction with mem[program_counter[ADDR_BITS+1:2]], if_pc_next with program_counter+4, set if_valid=1, and set program_counter to program_counter+4; ADDR_BITS=log2(MEM_DEPTH).
REQ-026 Latency: the word at program_counter SHALL appear on if_instruction one cycle after its fetch cycle.
REQ-027 A fetch address at or beyond MEM_DEPTH*4 SHALL read zero (NOP); PC arithmetic SHALL wrap modulo 2^PC_LENGTH.
REQ-028 In RUN or STEP, stall=1 with jump=0 SHALL hold program_counter and all IF/ID registers unchanged.
REQ-029 In RUN or STEP, jump=1 SHALL load program_counter with pc_with_jump and clear if_valid, with if_instruction set to zero; jump has priority over stall and over step.
REQ-030 When a fetched word equals HALT_WORD, it SHALL still be registered with if_valid=1; the FSM then enters HALTED the same edge, with halted=1 and program_counter frozen.
REQ-031 In HALTED, if_valid SHALL drop to 0 one cycle after entry; only reset exits HALTED.
REQ-032 In states other than RUN or STEP (no fetch), if_valid SHALL be 0.
REQ-033 Memory writes SHALL occur only in IDLE or HALTED with wr_memory_instruction_enable=1 and address_to_write below MEM_DEPTH*4; other writes are ignored.
REQ-034 A write and a fetch never coincide (guaranteed by REQ-033); the write index SHALL be address_to_write[ADDR_BITS+1:2].
REQ-035 mips_enable deassertion in RUN or STEP SHALL have no effect; only reset or halt leaves these states.

Reset
REQ-036 reset=1 SHALL set state=IDLE, program_counter=0, if_instruction=0, if_pc_next=0, if_valid=0, and halted=0 at the next edge, from any state.
REQ-037 Reset SHALL NOT clear instruction memory contents, and reset SHALL override all other inputs.

Structure
REQ-038 A shared package fetch_pkg SHALL hold the state encodings, the default HALT_WORD, and the NOP value.
REQ-039 Instruction storage SHALL be a sub-module instr_mem, with a synchronous write and an asynchronous read, parametrised by width and depth.

Verification
REQ-040 Load 0x11,0x22,0x33 at byte addresses 0,4,8, then start RUN -> if_instruction shows 0x11,0x22,0x33 on consecutive cycles, with if_pc_next 4,8,12.
REQ-041 Assert stall for 2 cycles while in RUN at PC=8 -> program_counter stays 8 and IF/ID is unchanged for 2 cycles.
REQ-042 Assert jump with pc_with_jump=0x40 and stall=1 -> program_counter=0x40, if_valid=0 on the next cycle.
REQ-043 Put HALT_WORD at address 12 -> halted=1 after its fetch, program_counter holds 16, and a write to address 0 afterwards succeeds.
REQ-044 Use step_mode=1 with 3 step pulses spaced apart -> program_counter=12, with exactly 3 cycles of if_valid=1.
REQ-045 Assert reset in RUN at PC=0x20 -> state=IDLE, all outputs 0, and memory still reads the loaded words after restart.
